// File: rtl/uart_tx_frame.sv
// UART transmitter: configurable data width, parity and stop bits, run-time bit divisor,
// valid/ready input with a one-word holding buffer so consecutive frames run back to back.
module uart_tx_frame #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic [DATA_BITS-1:0] i_TX_Data,
  input  logic                 i_TX_Valid,
  output logic                 o_TX_Ready,
  input  logic [DIV_WIDTH-1:0] i_Clks_Per_Bit,
  output logic                 o_TX_Busy,
  output logic                 o_TX_Done,
  output logic                 o_TX_Serial
);

  localparam int   BCW = $clog2(DATA_BITS) + 1;
  localparam logic ODD = (PARITY == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] hold_q;
  logic                 hold_full;
  logic                 par_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] clk_cnt;
  logic [BCW-1:0]       bit_cnt;

  logic                 xfer;
  logic                 bit_end;
  logic                 frame_end;
  logic                 start_frame;
  logic [DIV_WIDTH-1:0] div_eff;
  logic [DATA_BITS-1:0] next_word;

  assign o_TX_Ready = ~hold_full;

  always_comb begin
    xfer        = i_TX_Valid && !hold_full;
    div_eff     = (i_Clks_Per_Bit < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : i_Clks_Per_Bit;
    bit_end     = (clk_cnt == div_q - DIV_WIDTH'(1));
    frame_end   = (state == S_STOP) && bit_end && (bit_cnt == BCW'(STOP_BITS - 1));
    // At frame end a word arriving with an empty buffer goes straight into the shifter,
    // which is equivalent to buffering it and starting it with no idle cycle.
    start_frame = ((state == S_IDLE) && xfer) || (frame_end && (hold_full || xfer));
    next_word   = hold_full ? hold_q : i_TX_Data;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= S_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full   <= 1'b0;
      par_q       <= 1'b0;
      div_q       <= '0;
      clk_cnt     <= '0;
      bit_cnt     <= '0;
      o_TX_Busy   <= 1'b0;
      o_TX_Done   <= 1'b0;
      o_TX_Serial <= 1'b1;
    end else begin
      o_TX_Done <= 1'b0;

      if (xfer && (state != S_IDLE) && !frame_end) begin
        hold_q    <= i_TX_Data;
        hold_full <= 1'b1;
      end

      if (state != S_IDLE)
        clk_cnt <= bit_end ? '0 : clk_cnt + DIV_WIDTH'(1);

      case (state)
        S_IDLE: begin
          o_TX_Serial <= 1'b1;
          o_TX_Busy   <= 1'b0;
        end
        S_START: begin
          if (bit_end) begin
            state       <= S_DATA;
            o_TX_Serial <= shift_q[0];
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_cnt == BCW'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                state       <= S_PAR;
                o_TX_Serial <= par_q;
              end else begin
                state       <= S_STOP;
                o_TX_Serial <= 1'b1;
              end
            end else begin
              bit_cnt     <= bit_cnt + BCW'(1);
              shift_q     <= shift_q >> 1;
              o_TX_Serial <= shift_q[1];
            end
          end
        end
        S_PAR: begin
          if (bit_end) begin
            state       <= S_STOP;
            o_TX_Serial <= 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (bit_cnt == BCW'(STOP_BITS - 1)) begin
              o_TX_Done   <= 1'b1;
              state       <= S_IDLE;
              o_TX_Busy   <= 1'b0;
              o_TX_Serial <= 1'b1;
              bit_cnt     <= '0;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // Frame launch overrides the end-of-frame return to idle above.
      if (start_frame) begin
        shift_q     <= next_word;
        par_q       <= (^next_word) ^ ODD;
        div_q       <= div_eff;
        clk_cnt     <= '0;
        bit_cnt     <= '0;
        state       <= S_START;
        o_TX_Serial <= 1'b0;
        o_TX_Busy   <= 1'b1;
        if (hold_full)
          hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations share one stimulus stream; each is tracked by a
// queue-of-line-values reference model, plus directed frame tables and corner sequences.
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [8:0]  data = '0;
  logic [15:0] div = 16'd4;
  logic [3:0]  ser, rdy, bsy, dn;

  int errors = 0;
  int checks = 0;
  int done_total0 = 0;

  always #5 clk = ~clk;

  // 0: 8N1   1: 8E2   2: 8O2   3: 9O1
  localparam int DB [4] = '{8, 8, 8, 9};
  localparam int PM [4] = '{0, 1, 2, 2};
  localparam int SB [4] = '{1, 2, 2, 1};

  uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_WIDTH(16)) u0 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_Data(data[7:0]), .i_TX_Valid(valid), .o_TX_Ready(rdy[0]),
    .i_Clks_Per_Bit(div), .o_TX_Busy(bsy[0]), .o_TX_Done(dn[0]), .o_TX_Serial(ser[0]));
  uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .DIV_WIDTH(16)) u1 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_Data(data[7:0]), .i_TX_Valid(valid), .o_TX_Ready(rdy[1]),
    .i_Clks_Per_Bit(div), .o_TX_Busy(bsy[1]), .o_TX_Done(dn[1]), .o_TX_Serial(ser[1]));
  uart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .DIV_WIDTH(16)) u2 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_Data(data[7:0]), .i_TX_Valid(valid), .o_TX_Ready(rdy[2]),
    .i_Clks_Per_Bit(div), .o_TX_Busy(bsy[2]), .o_TX_Done(dn[2]), .o_TX_Serial(ser[2]));
  uart_tx_frame #(.DATA_BITS(9), .PARITY(2), .STOP_BITS(1), .DIV_WIDTH(16)) u3 (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_Data(data), .i_TX_Valid(valid), .o_TX_Ready(rdy[3]),
    .i_Clks_Per_Bit(div), .o_TX_Busy(bsy[3]), .o_TX_Done(dn[3]), .o_TX_Serial(ser[3]));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: expected line value for every future cycle ----------------
  bit         lq [4][$];
  bit         m_hold_full [4];
  logic [8:0] m_hold [4];
  bit         m_done [4];

  task automatic push_frame(input int g, input logic [8:0] d, input logic [15:0] dv);
    int         n;
    bit         bits[$];
    logic [8:0] msk;
    n   = (dv < 2) ? 2 : int'(dv);
    msk = 9'((1 << DB[g]) - 1);
    bits.push_back(1'b0);
    for (int i = 0; i < DB[g]; i++) bits.push_back(d[i]);
    if (PM[g] != 0) bits.push_back((^(d & msk)) ^ (PM[g] == 2));
    for (int s = 0; s < SB[g]; s++) bits.push_back(1'b1);
    foreach (bits[i]) repeat (n) lq[g].push_back(bits[i]);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int g = 0; g < 4; g++) begin
      bit was_active;
      bit xf;
      if (!rst_n) begin
        lq[g].delete();
        m_hold_full[g] = 1'b0;
        m_done[g] = 1'b0;
      end else begin
        xf = valid && !m_hold_full[g];
        was_active = (lq[g].size() != 0);
        m_done[g] = 1'b0;
        if (was_active) void'(lq[g].pop_front());
        if (lq[g].size() == 0) begin
          if (was_active) m_done[g] = 1'b1;
          if (m_hold_full[g]) begin
            push_frame(g, m_hold[g], div);
            m_hold_full[g] = 1'b0;
          end else if (xf) begin
            push_frame(g, data, div);
          end
        end else if (xf) begin
          m_hold[g] = data;
          m_hold_full[g] = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (dn[0]) done_total0++;
    for (int g = 0; g < 4; g++) begin
      logic [3:0] e;
      e = {(lq[g].size() != 0) ? lq[g][0] : 1'b1, !m_hold_full[g], lq[g].size() != 0, m_done[g]};
      check($sformatf("model_cfg%0d{ser,rdy,busy,done}", g), {ser[g], rdy[g], bsy[g], dn[g]}, e);
    end
  end

  // ---------------- helpers ----------------
  task automatic offer(input logic [8:0] d, input logic [15:0] dv);
    @(negedge clk);
    valid = 1'b1;
    data  = d;
    div   = dv;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bsy != 4'h0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", int'(bsy), 0);
  endtask

  task automatic done_at(input int g, output int at);
    at = -1;
    for (int k = 1; k <= 1000; k++) begin
      if (k > 1) @(negedge clk);
      if (dn[g]) begin
        at = k;
        break;
      end
    end
  endtask

  typedef struct {
    int          g;
    logic [8:0]  d;
    logic [15:0] dv;
    int          n;
    int          nb;
    logic [11:0] seq;  // transmitted bits, first on the left
  } vec_t;

  vec_t tv [7];

  initial begin
    int at;
    int d0;
    int k;

    tv[0] = '{0, 9'h0A5, 16'd4, 4, 10, 12'b0101001011};
    tv[1] = '{1, 9'h007, 16'd3, 3, 12, 12'b011100000111};
    tv[2] = '{2, 9'h007, 16'd3, 3, 12, 12'b011100000011};
    tv[3] = '{1, 9'h000, 16'd3, 3, 12, 12'b000000000011};
    tv[4] = '{3, 9'h1FF, 16'd3, 3, 12, 12'b011111111101};
    tv[5] = '{0, 9'h000, 16'd0, 2, 10, 12'b0000000001};
    tv[6] = '{0, 9'h03C, 16'd1, 2, 10, 12'b0001111001};

    // reset held with valid asserted
    valid = 1'b1;
    data  = 9'h1A5;
    repeat (3) begin
      @(negedge clk);
      check("reset_hold", {ser, rdy, bsy, dn}, {4'hF, 4'hF, 4'h0, 4'h0});
    end
    valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_nostart", {ser, bsy}, {4'hF, 4'h0});

    // directed frames
    for (int e = 0; e < 7; e++) begin
      wait_idle();
      offer(tv[e].d, tv[e].dv);
      for (int c = 1; c <= tv[e].nb * tv[e].n; c++) begin
        if (c > 1) @(negedge clk);
        check($sformatf("frame%0d_{done,ser}", e), {dn[tv[e].g], ser[tv[e].g]},
              {1'b0, tv[e].seq[tv[e].nb - 1 - (c - 1) / tv[e].n]});
      end
      @(negedge clk);
      check($sformatf("frame%0d_done", e), dn[tv[e].g], 1);
    end

    // back-to-back on cfg0, div 2
    wait_idle();
    d0 = done_total0;
    offer(9'h055, 16'd2);
    repeat (4) @(negedge clk);
    offer(9'h0AA, 16'd2);
    check("b2b_ready_drop", int'(rdy), 0);
    valid = 1'b1;
    data  = 9'h00F;
    k = 0;
    while (!rdy[0] && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("b2b_ready_return", rdy[0], 1);
    check("b2b_nogap_{done,ser,busy}", {dn[0], ser[0], bsy[0]}, 3'b101);
    @(negedge clk);
    valid = 1'b0;
    wait_idle();
    @(negedge clk);
    check("b2b_done_count", done_total0 - d0, 3);

    // divisor change mid-frame, then the new divisor on the next frame
    wait_idle();
    offer(9'h05A, 16'd4);
    div = 16'd8;
    done_at(0, at);
    check("div_keep_4", at, 41);
    wait_idle();
    offer(9'h05A, 16'd8);
    done_at(0, at);
    check("div_new_8", at, 81);

    // reset mid-frame with a word buffered
    wait_idle();
    offer(9'h033, 16'd4);
    offer(9'h044, 16'd4);
    repeat (12) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("midreset_line_busy", {ser, bsy}, {4'hF, 4'h0});
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midreset_after", {ser, rdy, bsy}, {4'hF, 4'hF, 4'h0});
    end

    // random traffic against the model
    repeat (2500) begin
      @(negedge clk);
      valid = ($urandom_range(0, 3) == 0);
      data  = 9'($urandom);
      div   = 16'($urandom_range(0, 5));
    end
    @(negedge clk);
    valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Parametrised successor to the team's fixed 8N1 UART transmitter.
- Supports a configurable data width, optional even or odd parity, and 1 or 2 stop bits.
- The bit period is set at run time by a divisor input instead of a fixed parameter.
- A valid/ready handshake and a one-entry holding buffer allow back-to-back frames with no idle gap.
- Sits between the CPU's UART register interface and the TX pin.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.
- DIV_WIDTH, 16, width of the clocks-per-bit divisor input.

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  asynchronous active-low reset
- i_TX_Data  in  DATA_BITS  byte/word to send
- i_TX_Valid  in  1  data valid; a transfer occurs when i_TX_Valid && o_TX_Ready on a rising clock edge
- o_TX_Ready  out  1  holding buffer can accept a word
- i_Clks_Per_Bit  in  DIV_WIDTH  bit period in clocks; latched at the start of each frame
- o_TX_Busy  out  1  frame in progress
- o_TX_Done  out  1  one-cycle pulse at frame end
- o_TX_Serial  out  1  serial line, idle high

Behaviour:
- Reset (asynchronous, active-low): o_TX_Serial=1, o_TX_Ready=1, o_TX_Busy=0, o_TX_Done=0, holding buffer empty, state IDLE, all counters 0. Asserting reset mid-frame aborts the frame and drives the line high immediately; the buffered word is discarded.
- States: IDLE, START, DATA, PARITY, STOP.
  - PARITY is skipped when PARITY=0.
  - STOP lasts STOP_BITS bit periods.
- Divisor: N = i_Clks_Per_Bit sampled on the cycle a frame starts. Values 0 and 1 are treated as 2. Changing the input mid-frame has no effect on the current frame.
- IDLE with a transfer at edge T:
  - The word is loaded directly into the shift register; the holding buffer is bypassed.
  - From T+1: START, o_TX_Serial=0, o_TX_Busy=1.
  - o_TX_Ready stays 1, because the buffer is still empty.
- Each bit is held for exactly N clocks.
- DATA sends bits LSB first, DATA_BITS bits in total.
- Parity bit:
  - Even: XOR of the data bits.
  - Odd: inverse of the even value.
- Stop bit(s): line = 1.
- Frame length = N*(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) cycles.
- Transfer during a frame (buffer empty):
  - The word is stored in the holding buffer.
  - o_TX_Ready = 0 from the next cycle until the buffer is consumed.
- Last cycle of the final stop bit:
  - o_TX_Done pulses high for one cycle, on the cycle after that last stop cycle.
  - Buffer full: the next cycle starts START with the buffered word and a freshly sampled N (no idle cycle). o_TX_Busy stays 1; o_TX_Ready returns to 1 on that same cycle.
  - Buffer empty: go to IDLE. o_TX_Busy=0 and o_TX_Serial=1 on that cycle.
- Simultaneous frame end and new transfer (buffer empty, valid high on the last stop cycle): the new word is buffered and then started back-to-back; no word is lost and no gap is inserted.
- i_TX_Valid while o_TX_Ready=0 is ignored; the source must hold the data stable.
- o_TX_Done and o_TX_Busy are registered. o_TX_Serial is registered and glitch-free.
- Bit counter width = clog2(DATA_BITS) + 1. Clock counter width = DIV_WIDTH.

Test Plan:
- Reset:
  - Hold i_Rst_L=0 for 3 cycles with i_TX_Valid=1 -> Serial=1, Ready=1, Busy=0, Done=0 throughout; no frame starts.
  - Assert reset at cycle 15 of a frame -> line high immediately; Ready=1 and Busy=0 after release.
- Basic 8N1 (DATA_BITS=8, PARITY=0, STOP_BITS=1, div=4), send 0xA5:
  - Line sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total).
  - Done pulses once, 41 cycles after the accept edge.
- Parity and 2 stop bits (div=3, STOP_BITS=2):
  - PARITY=1, send 0x07 -> parity bit 1, frame = 12 bits = 36 cycles.
  - PARITY=2, send 0x07 -> parity bit 0.
  - PARITY=1, send 0x00 -> parity bit 0.
- Back-to-back (div=2):
  - Send 0x55, then 0xAA 5 cycles later -> Ready drops the cycle after the second accept.
  - Present 0x0F immediately after -> held off until Ready returns.
  - The start bit of 0xAA follows the 0x55 stop bit with zero idle cycles.
  - One Done pulse per frame, three frames total.
- Divisor handling:
  - Change div 4->8 mid-frame -> the current frame stays at 4 cycles/bit; the next frame uses 8.
  - div=0 -> 2 cycles/bit.
- 9-bit data (DATA_BITS=9, PARITY=2), send 0x1FF:
  - Nine data 1s, then odd parity bit 0, then stop bit.
  - Done pulses after exactly 12*N cycles.
